// File: rtl/hour_display_mux.sv
// Two-digit multiplexed 7-segment driver for the 0..12 hour counter.
// The value is captured once per frame, so the units and tens digits always show the same sample.
module hour_display_mux #(
   parameter int REFRESH_DIV  = 50000,
   parameter int MAX_VAL      = 12,
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] count_in,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [1:0] dig_en,
   output logic       err
);

   localparam int             RC_W     = $clog2(REFRESH_DIV);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
   localparam logic [3:0]     MAX_HOLD = 4'(MAX_VAL);
   localparam logic [6:0]     SEG_DASH = 7'b0000001;
   localparam logic [6:0]     SEG_OFF  = COMMON_ANODE ? 7'b1111111 : 7'b0000000;
   localparam logic [1:0]     DIG_OFF  = COMMON_ANODE ? 2'b11 : 2'b00;

   typedef enum logic {
      UNITS = 1'b0,
      TENS  = 1'b1
   } digit_t;

   digit_t          digit;
   digit_t          digit_next;
   logic [RC_W-1:0] rc;
   logic            tick;
   logic [3:0]      hold;
   logic            out_of_range;
   logic            tens_one;
   logic [3:0]      units_val;
   logic [6:0]      seg_raw;
   logic [1:0]      dig_raw;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1111110;
         4'd1:    seg_of = 7'b0110000;
         4'd2:    seg_of = 7'b1101101;
         4'd3:    seg_of = 7'b1111001;
         4'd4:    seg_of = 7'b0110011;
         4'd5:    seg_of = 7'b1011011;
         4'd6:    seg_of = 7'b1011111;
         4'd7:    seg_of = 7'b1110000;
         4'd8:    seg_of = 7'b1111111;
         4'd9:    seg_of = 7'b1111011;
         default: seg_of = SEG_DASH;
      endcase
   endfunction

   assign tick = (rc == RC_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rc <= '0;
      end else if (tick) begin
         rc <= '0;
      end else begin
         rc <= rc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         digit <= UNITS;
      end else begin
         digit <= digit_next;
      end
   end

   always_comb begin
      digit_next = digit;
      if (tick) begin
         digit_next = (digit == UNITS) ? TENS : UNITS;
      end
   end

   // The end of the tens slot is the frame boundary; only there may the shown value change.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold <= 4'd0;
      end else if (tick && (digit == TENS)) begin
         hold <= count_in;
      end
   end

   always_comb begin
      out_of_range = (hold > MAX_HOLD);
      tens_one     = (hold >= 4'd10);
      units_val    = tens_one ? (hold - 4'd10) : hold;
   end

   // Leading zero keeps its digit enable so both slots share the same duty cycle.
   always_comb begin
      seg_raw = 7'b0000000;
      dig_raw = 2'b00;
      if (!blank) begin
         dig_raw = (digit == UNITS) ? 2'b01 : 2'b10;
         if (out_of_range) begin
            seg_raw = SEG_DASH;
         end else if (digit == UNITS) begin
            seg_raw = seg_of(units_val);
         end else if (tens_one) begin
            seg_raw = seg_of(4'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         seg    <= SEG_OFF;
         dig_en <= DIG_OFF;
         err    <= 1'b0;
      end else begin
         seg    <= COMMON_ANODE ? ~seg_raw : seg_raw;
         dig_en <= COMMON_ANODE ? ~dig_raw : dig_raw;
         err    <= out_of_range;
      end
   end

endmodule
